// File: rtl/gpu_pkg.sv
// Shared constants for the foreground sprite path: object count and scanline geometry.
package gpu_pkg;

    localparam int NUM_OBJECTS_DEFAULT = 64;
    localparam int PIXEL_W             = 2;
    localparam int PIXELS_PER_LINE     = 8;
    localparam int LINE_W              = PIXEL_W * PIXELS_PER_LINE;

endpackage : gpu_pkg

// File: rtl/ffs_m.sv
// Combinational find-first-set: index of the lowest set request bit, built as a
// balanced binary tree over the request vector padded to a power of two.
module ffs_m #(
    parameter int NUM_OBJECTS = 64,
    parameter int IDX_W       = $clog2(NUM_OBJECTS)
) (
    input  logic [NUM_OBJECTS-1:0] req_vec,
    output logic                   valid,
    output logic [IDX_W-1:0]       index
);

    localparam int LEAVES = 1 << IDX_W;

    // Heap-ordered tree: node n has children 2n and 2n+1, leaves sit at LEAVES..2*LEAVES-1.
    logic             node_v   [1:2*LEAVES-1];
    logic [IDX_W-1:0] node_idx [1:2*LEAVES-1];

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < NUM_OBJECTS) begin : g_real
            assign node_v[LEAVES+i] = req_vec[i];
        end else begin : g_pad
            assign node_v[LEAVES+i] = 1'b0;
        end
        assign node_idx[LEAVES+i] = IDX_W'(i);
    end

    // An empty left subtree hands over to the right one; a fully empty tree
    // keeps selecting left, so the root index falls back to 0.
    for (genvar n = 1; n < LEAVES; n++) begin : g_node
        assign node_v[n]   = node_v[2*n] | node_v[2*n+1];
        assign node_idx[n] = (node_v[2*n] || !node_v[2*n+1]) ? node_idx[2*n] : node_idx[2*n+1];
    end

    assign valid = node_v[1];
    assign index = node_idx[1];

endmodule : ffs_m

// File: rtl/pattern_hflipper_m.sv
// Combinational horizontal mirror of a 2-bpp scanline: pixels reverse, bits within a pixel do not.
module pattern_hflipper_m
    import gpu_pkg::*;
(
    input  logic [LINE_W-1:0] line_in,
    input  logic              hflip,
    output logic [LINE_W-1:0] line_out
);

    always_comb begin
        // NOTE: assign a default first so every path drives line_out and no latch is inferred.
        line_out = line_in;
        if (hflip) begin
            for (int k = 0; k < PIXELS_PER_LINE; k++) begin
                line_out[PIXEL_W*k +: PIXEL_W] = line_in[PIXEL_W*(PIXELS_PER_LINE-1-k) +: PIXEL_W];
            end
        end
    end

endmodule : pattern_hflipper_m

// File: rtl/ffs_pattern_select.sv
// Priority-select plus pattern-flip stage: both combinational results share one output register bank.
module ffs_pattern_select
    import gpu_pkg::*;
#(
    parameter int NUM_OBJECTS = NUM_OBJECTS_DEFAULT,
    parameter int IDX_W       = $clog2(NUM_OBJECTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_OBJECTS-1:0] valid_vec,
    input  logic [LINE_W-1:0]      line_in,
    input  logic                   hflip,
    output logic                   any_valid,
    output logic [IDX_W-1:0]       top_idx,
    output logic [LINE_W-1:0]      line_out
);

    logic              ffs_valid;
    logic [IDX_W-1:0]  ffs_index;
    logic [LINE_W-1:0] flip_line;

    logic              any_valid_d, any_valid_q;
    logic [IDX_W-1:0]  top_idx_d,   top_idx_q;
    logic [LINE_W-1:0] line_out_d,  line_out_q;

    ffs_m #(
        .NUM_OBJECTS (NUM_OBJECTS),
        .IDX_W       (IDX_W)
    ) u_ffs (
        .req_vec (valid_vec),
        .valid   (ffs_valid),
        .index   (ffs_index)
    );

    pattern_hflipper_m u_flip (
        .line_in  (line_in),
        .hflip    (hflip),
        .line_out (flip_line)
    );

    always_comb begin
        any_valid_d = ffs_valid;
        top_idx_d   = ffs_index;
        line_out_d  = flip_line;
    end

    // rst is active-low and asynchronous: outputs clear the moment it falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            any_valid_q <= 1'b0;
            top_idx_q   <= '0;
            line_out_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples its pre-edge value.
            any_valid_q <= any_valid_d;
            top_idx_q   <= top_idx_d;
            line_out_q  <= line_out_d;
        end
    end

    assign any_valid = any_valid_q;
    assign top_idx   = top_idx_q;
    assign line_out  = line_out_q;

endmodule : ffs_pattern_select

// File: tb/tb_ffs_pattern_select.sv
// Bench for ffs_pattern_select: vector table, reset/flip corner sequences and a
// randomized run against a pixel-level reference model, on 64- and 24-object instances.
module tb_ffs_pattern_select;

    logic        clk;
    logic        rst;
    logic [63:0] valid_vec;
    logic [23:0] valid_vec24;
    logic [15:0] line_in;
    logic        hflip;

    logic        any_valid,  any_valid24;
    logic [5:0]  top_idx;
    logic [4:0]  top_idx24;
    logic [15:0] line_out,   line_out24;

    int checks = 0;
    int errors = 0;

    ffs_pattern_select #(.NUM_OBJECTS(64)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .valid_vec (valid_vec),
        .line_in   (line_in),
        .hflip     (hflip),
        .any_valid (any_valid),
        .top_idx   (top_idx),
        .line_out  (line_out)
    );

    ffs_pattern_select #(.NUM_OBJECTS(24)) u_dut24 (
        .clk       (clk),
        .rst       (rst),
        .valid_vec (valid_vec24),
        .line_in   (line_in),
        .hflip     (hflip),
        .any_valid (any_valid24),
        .top_idx   (top_idx24),
        .line_out  (line_out24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: scan objects in priority order; rebuild the line pixel by pixel.
    function automatic int ref_idx(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic ref_any(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) if (v[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] ref_line(input logic [15:0] li, input logic hf);
        logic [1:0]  pix [8];
        logic [15:0] o;
        for (int p = 0; p < 8; p++) pix[p] = li[15-2*p -: 2];
        for (int p = 0; p < 8; p++) o[15-2*p -: 2] = hf ? pix[7-p] : pix[p];
        return o;
    endfunction

    typedef struct {
        string       name;
        logic [63:0] vv;
        logic [15:0] li;
        logic        hf;
        logic        ea;
        logic [5:0]  ei;
        logic [15:0] el;
    } vec_t;

    vec_t tbl [8];

    task automatic drive(input logic [63:0] vv, input logic [23:0] vv24, input logic [15:0] li, input logic hf);
        @(negedge clk);
        valid_vec   = vv;
        valid_vec24 = vv24;
        line_in     = li;
        hflip       = hf;
    endtask

    initial begin
        logic [15:0] r, y;
        logic        exp_any, exp_any24;
        int          exp_idx, exp_idx24;
        logic [15:0] exp_line;

        tbl[0] = '{"ffs_5_40_flip", (64'd1 << 5) | (64'd1 << 40), 16'hE400, 1'b1, 1'b1, 6'd5,  16'h001B};
        tbl[1] = '{"ffs_63_noflip", 64'd1 << 63,                 16'hE400, 1'b0, 1'b1, 6'd63, 16'hE400};
        tbl[2] = '{"ffs_all_block", {64{1'b1}},                  16'hC0AB, 1'b1, 1'b1, 6'd0,  16'hEA03};
        tbl[3] = '{"ffs_empty",     64'd0,                       16'h1234, 1'b0, 1'b0, 6'd0,  16'h1234};
        tbl[4] = '{"ffs_bit0",      64'd1,                       16'hFFFF, 1'b1, 1'b1, 6'd0,  16'hFFFF};
        tbl[5] = '{"ffs_1_63",      (64'd1 << 1) | (64'd1 << 63), 16'h8000, 1'b1, 1'b1, 6'd1, 16'h0002};
        tbl[6] = '{"ffs_32",        64'd1 << 32,                 16'h0001, 1'b1, 1'b1, 6'd32, 16'h4000};
        tbl[7] = '{"ffs_hi_half",   64'hFFFF_0000_0000_0000,     16'h9C3A, 1'b0, 1'b1, 6'd48, 16'h9C3A};

        // Reset with random inputs present: outputs must be zero without any clock edge.
        rst         = 1'b0;
        valid_vec   = {$urandom, $urandom};
        valid_vec24 = 24'($urandom);
        line_in     = 16'($urandom);
        hflip       = 1'b1;
        #1;
        check("rst_any",  64'(any_valid), 64'd0);
        check("rst_idx",  64'(top_idx),   64'd0);
        check("rst_line", 64'(line_out),  64'd0);
        @(posedge clk); #1;
        check("rst_hold_line", 64'(line_out), 64'd0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_release_noedge", 64'(line_out), 64'd0);

        foreach (tbl[t]) begin
            drive(tbl[t].vv, 24'd0, tbl[t].li, tbl[t].hf);
            @(posedge clk); #1;
            check({tbl[t].name, "_any"},  64'(any_valid), 64'(tbl[t].ea));
            check({tbl[t].name, "_idx"},  64'(top_idx),   64'(tbl[t].ei));
            check({tbl[t].name, "_line"}, 64'(line_out),  64'(tbl[t].el));
        end

        // Mid-stream reset: outputs are non-zero here and must clear asynchronously.
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_any",  64'(any_valid), 64'd0);
        check("midrst_line", 64'(line_out),  64'd0);
        @(posedge clk); #1;
        check("midrst_hold_idx", 64'(top_idx), 64'd0);
        drive(64'd1 << 9, 24'd1 << 3, 16'h5A5A, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_noedge_any", 64'(any_valid), 64'd0);
        @(posedge clk); #1;
        check("midrst_track_idx",  64'(top_idx),  64'd9);
        check("midrst_track_line", 64'(line_out), 64'h5A5A);

        // One-hot sweep: each result lands one edge after its inputs.
        for (int i = 0; i < 64; i++) begin
            drive(64'd1 << i, 24'd0, 16'h0000, 1'b0);
            @(posedge clk); #1;
            check($sformatf("onehot_%0d", i), 64'(top_idx), 64'(i));
        end

        // Narrow instance: only its top object set.
        drive(64'd0, 24'd1 << 23, 16'h0000, 1'b0);
        @(posedge clk); #1;
        check("n24_bit23_idx", 64'(top_idx24),  64'd23);
        check("n24_bit23_any", 64'(any_valid24), 64'd1);

        // Flip twice through the DUT returns the original line.
        for (int k = 0; k < 8; k++) begin
            r = 16'($urandom);
            drive(64'd0, 24'd0, r, 1'b1);
            @(posedge clk); #1;
            y = line_out;
            drive(64'd0, 24'd0, y, 1'b1);
            @(posedge clk); #1;
            check($sformatf("double_flip_%0d", k), 64'(line_out), 64'(r));
        end

        // Random stream against the model; also confirm outputs hold until the edge.
        exp_line = line_out;
        for (int k = 0; k < 300; k++) begin
            logic [63:0] v;
            logic [15:0] li;
            logic        hf;
            v = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: v = 64'd0;
                1: v = v & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                2: v = 64'd1 << $urandom_range(0, 63);
                default: ;
            endcase
            li = 16'($urandom);
            hf = 1'($urandom);
            drive(v, v[23:0], li, hf);
            #1;
            if (k > 0) check("stream_hold_line", 64'(line_out), 64'(exp_line));
            exp_any   = ref_any(v, 64);
            exp_idx   = ref_idx(v, 64);
            exp_any24 = ref_any(v, 24);
            exp_idx24 = ref_idx(v, 24);
            exp_line  = ref_line(li, hf);
            @(posedge clk); #1;
            check("rand_any",    64'(any_valid),   64'(exp_any));
            check("rand_idx",    64'(top_idx),     64'(exp_idx));
            check("rand_line",   64'(line_out),    64'(exp_line));
            check("rand24_any",  64'(any_valid24), 64'(exp_any24));
            check("rand24_idx",  64'(top_idx24),   64'(exp_idx24));
            check("rand24_line", 64'(line_out24),  64'(exp_line));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ffs_pattern_select

// File: doc/ffs_pattern_select.md
# ffs_pattern_select

Registered priority-select and pattern-flip stage for the foreground sprite path. It finds the highest-priority object among the per-object "pixel valid" flags, where the lowest index wins. In parallel it horizontally mirrors a 16-bit, 2-bpp pattern scanline on request. Both results come out through a single output register stage.

## Interface
Parameters:
- `NUM_OBJECTS`, default 64: width of the request vector; legal range 2..256; need not be a power of two.
- `IDX_W`, default `$clog2(NUM_OBJECTS)`: width of the index output (derived; not overridden).

Ports:
- `clk`  in  1: single clock; all state on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `valid_vec`  in  NUM_OBJECTS: per-object valid flags; bit 0 has the highest priority.
- `line_in`  in  16: one pattern scanline, 8 pixels × 2 bits.
- `hflip`  in  1: 1 = mirror `line_in` horizontally.
- `any_valid`  out  1: registered; 1 when any bit of `valid_vec` was set.
- `top_idx`  out  IDX_W: registered index of the lowest set bit of `valid_vec`.
- `line_out`  out  16: registered, optionally mirrored scanline.

## Operation
Find-first-set:
- `top_idx` = smallest i with `valid_vec[i]`=1.
- `any_valid` = OR-reduction of `valid_vec`.
- When `valid_vec`=0: `any_valid`=0 and `top_idx`=0.
- Bits above NUM_OBJECTS−1 do not exist; the index never exceeds NUM_OBJECTS−1.
- Implement as a parallel priority tree; no sequential scan.

Pixel layout:
- Pixel p (p=0 leftmost) occupies `line[15−2p : 14−2p]`, so pixel 0 is bits 15:14 and pixel 7 is bits 1:0.

Horizontal flip:
- With hflip=1: output pixel p = input pixel 7−p, i.e. `out[2k+1:2k] = in[2(7−k)+1 : 2(7−k)]`.
- The two bits inside a pixel keep their order. Pixels are reversed, not individual bits.
- With hflip=0: output = input.

Both functions are purely combinational ahead of the output register. There are no other state bits and no FSM.

## Timing
- Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is 1 result per cycle; no handshake, no stall.
- Reset assertion (`rst`=0) immediately and asynchronously forces `any_valid`=0, `top_idx`=0, `line_out`=16'h0000. This includes assertion mid-stream.
- Outputs hold their reset values until the first rising edge after `rst` returns to 1. That edge loads the then-present inputs.
- `valid_vec` changing every cycle: each cycle's result depends only on that cycle's inputs. No history, no hysteresis.
- Simultaneous multiple set bits: the lowest index always wins, regardless of the count.

## Structure
- Shared package `gpu_pkg`: `NUM_OBJECTS_DEFAULT`=64, `PIXEL_W`=2, `PIXELS_PER_LINE`=8, `LINE_W`=16.
- Sub-modules:
  - `ffs_m`: parameterised find-first-set, combinational, with outputs `valid` and `index`.
  - `pattern_hflipper_m`: combinational scanline mirror, with ports `line_in`, `hflip`, `line_out`.
- The top instantiates one of each and adds the output register bank.
- Write the `ffs_m` tree recursively or as a generate-based binary reduction so it scales to 256 inputs.

## Test plan
- Reset: drive `rst`=0 with random inputs → `any_valid`=0, `top_idx`=0, `line_out`=0000 immediately, without waiting for a clock. Deassert, then one edge → outputs track inputs.
- FFS single/multi: `valid_vec` bits {5,40} set → `any_valid`=1, `top_idx`=5. Only bit 63 → 63. All ones → 0.
- FFS empty: `valid_vec`=0 → `any_valid`=0, `top_idx`=0. Exhaustive one-hot sweep 0..63 → `top_idx`=i each cycle, one cycle late.
- Flip: `line_in`=16'b11_10_01_00_00_00_00_00, `hflip`=1 → `line_out`=16'b00_00_00_00_00_01_10_11. Same input with `hflip`=0 → unchanged.
- Pattern block: `line_in`=16'b11_00_00_00_10_10_10_11, `hflip`=1 → 16'b11_10_10_10_00_00_00_11. Random lines: flip applied twice equals the original.
- Parameter: `NUM_OBJECTS`=24 with only bit 23 set → `top_idx`=23, `IDX_W`=5. Random vectors are compared against a reference model every cycle with 1-cycle latency.
